// File: rtl/hist_pkg.sv
// Shared types and default sizing for the frame-level luma histogram controller.
package hist_pkg;

    localparam int NUM_BINS_DEF = 8;
    localparam int BIN_W_DEF    = 8;
    localparam int BIN_IDX_W    = $clog2(NUM_BINS_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ARMED  = 3'd2,
        ACCUM  = 3'd3,
        SETTLE = 3'd4,
        LATCH  = 3'd5
    } hist_state_e;

endpackage

// File: rtl/hist_snap_reader.sv
// Holds one frame snapshot of the accumulator bins and streams it out bin by bin.
// Optional HIST_FRAME_CTRL_DROP_CNT_EN adds a saturating count of discarded frames.
module hist_snap_reader
    import hist_pkg::*;
#(
    parameter  int NUM_BINS = NUM_BINS_DEF,
    parameter  int BIN_W    = BIN_W_DEF,
    localparam int IDX_W    = $clog2(NUM_BINS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      latch,
    input  logic [NUM_BINS*BIN_W-1:0] snap_in,
    output logic                      full,
    output logic [BIN_W-1:0]          bin_data,
    output logic [IDX_W-1:0]          bin_idx,
    input  logic                      bin_ready,
    output logic                      bin_last,
    output logic                      frame_drop
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);

    logic [NUM_BINS*BIN_W-1:0] snap_q, snap_d;
    logic                      full_q, full_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      drop_q, drop_d;
    logic                      accept, at_last;

    always_comb begin
        at_last = (idx_q == IDX_W'(NUM_BINS - 1));
        accept  = full_q & bin_ready;
        snap_d  = snap_q;
        full_d  = full_q;
        idx_d   = idx_q;
        drop_d  = 1'b0;
        if (accept) begin
            idx_d = at_last ? '0 : idx_q + 1'b1;
            if (at_last) full_d = 1'b0;
        end
        // An occupied snapshot wins over a new frame: the new one is dropped.
        if (latch) begin
            if (full_q) begin
                drop_d = 1'b1;
            end else begin
                snap_d = snap_in;
                full_d = 1'b1;
                idx_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            full_q <= full_d;
            idx_q  <= idx_d;
            drop_q <= drop_d;
        end
    end

    assign full       = full_q;
    assign bin_idx    = idx_q;
    assign bin_data   = full_q ? snap_q[int'(idx_q)*BIN_W +: BIN_W] : '0;
    assign bin_last   = full_q & at_last;
    assign frame_drop = drop_q;

`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: rtl/hist_frame_ctrl.sv
// Frame gating, snapshot and clear sequencing for the 8-bin luma histogram accumulator.
// Optional HIST_FRAME_CTRL_DROP_CNT_EN exposes a saturating drop counter on drop_cnt.
//
// state  | meaning
// IDLE   | disabled, accumulator untouched
// CLEAR  | id_clear asserted for one cycle
// ARMED  | waiting for a SOF beat
// ACCUM  | gating beats into the accumulator until EOF
// SETTLE | final increment lands in the accumulator
// LATCH  | snapshot captured (or frame dropped) at the end of this cycle
module hist_frame_ctrl
    import hist_pkg::*;
#(
    parameter  int NUM_BINS = NUM_BINS_DEF,
    parameter  int BIN_W    = BIN_W_DEF,
    localparam int IDX_W    = $clog2(NUM_BINS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hist_enable,
    input  logic                      video_valid,
    input  logic                      video_sof,
    input  logic                      video_eof,
    output logic                      accum_valid,
    output logic                      id_clear,
    input  logic [NUM_BINS*BIN_W-1:0] id_value,
    output logic [BIN_W-1:0]          bin_data,
    output logic [IDX_W-1:0]          bin_idx,
    output logic                      bin_valid,
    input  logic                      bin_ready,
    output logic                      bin_last,
    output logic                      frame_drop
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);

    hist_state_e state_q, state_d;
    logic        id_clear_q, id_clear_d;
    logic        sof_beat, eof_beat, latch;

    always_comb begin
        sof_beat = video_valid & video_sof;
        eof_beat = video_valid & video_eof;
        state_d  = state_q;
        if (!hist_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CLEAR;
                CLEAR:   state_d = ARMED;
                ARMED:   if (sof_beat) state_d = eof_beat ? SETTLE : ACCUM;
                ACCUM:   if (eof_beat) state_d = SETTLE;
                SETTLE:  state_d = LATCH;
                LATCH:   state_d = CLEAR;
                default: state_d = IDLE;
            endcase
        end
        id_clear_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            id_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_clear_q <= id_clear_d;
        end
    end

    // SOF beat in ARMED is gated too, so the first pixel of the frame is counted.
    assign accum_valid = video_valid & ((state_q == ACCUM) | ((state_q == ARMED) & video_sof));
    assign id_clear    = id_clear_q;
    assign latch       = (state_q == LATCH) & hist_enable;

    hist_snap_reader #(
        .NUM_BINS (NUM_BINS),
        .BIN_W    (BIN_W)
    ) u_reader (
        .clk        (clk),
        .rst        (rst),
        .latch      (latch),
        .snap_in    (id_value),
        .full       (bin_valid),
        .bin_data   (bin_data),
        .bin_idx    (bin_idx),
        .bin_ready  (bin_ready),
        .bin_last   (bin_last),
        .frame_drop (frame_drop)
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Directed bench for hist_frame_ctrl with a behavioural 8-bin accumulator (bin = pixel[7:5]).
module tb_hist_frame_ctrl;
    import hist_pkg::*;

    localparam int NB = 8;
    localparam int BW = 8;

    typedef logic [BW-1:0] bins_t [NB];

    logic          clk = 1'b0;
    logic          rst;
    logic          hist_enable, video_valid, video_sof, video_eof, bin_ready;
    logic [7:0]    pix;
    logic          accum_valid, id_clear, bin_valid, bin_last, frame_drop;
    logic [NB*BW-1:0] id_value;
    logic [BW-1:0] bin_data;
    logic [2:0]    bin_idx;
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int av_cnt = 0;

    always #5 clk = ~clk;

    hist_frame_ctrl #(.NUM_BINS(NB), .BIN_W(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .hist_enable (hist_enable),
        .video_valid (video_valid),
        .video_sof   (video_sof),
        .video_eof   (video_eof),
        .accum_valid (accum_valid),
        .id_clear    (id_clear),
        .id_value    (id_value),
        .bin_data    (bin_data),
        .bin_idx     (bin_idx),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_last    (bin_last),
        .frame_drop  (frame_drop)
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    logic [BW-1:0] acc [NB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) acc[i] <= '0;
        end else if (id_clear) begin
            for (int i = 0; i < NB; i++) acc[i] <= '0;
        end else if (accum_valid) begin
            acc[pix[7:5]] <= acc[pix[7:5]] + 8'd1;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_pack
        assign id_value[g*BW +: BW] = acc[g];
    end

    task automatic beat(input logic sof, input logic eof, input logic [7:0] p);
        @(negedge clk);
        video_valid = 1'b1;
        video_sof   = sof;
        video_eof   = eof;
        pix         = p;
        #1;
        if (accum_valid) av_cnt++;
    endtask

    task automatic gap();
        @(negedge clk);
        video_valid = 1'b0;
        video_sof   = 1'b0;
        video_eof   = 1'b0;
        #1;
        if (accum_valid) av_cnt++;
    endtask

    task automatic post_eof(input logic exp_drop, input logic full_before);
        gap();
        checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL settle_clear got=%0b exp=0", id_clear); end
        gap();
        checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL latch_clear got=%0b exp=0", id_clear); end
        checks++; if (bin_valid !== full_before) begin errors++; $display("FAIL latch_valid got=%0b exp=%0b", bin_valid, full_before); end
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL latch_drop got=%0b exp=0", frame_drop); end
        gap();
        checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL t3_clear got=%0b exp=1", id_clear); end
        checks++; if (bin_valid !== 1'b1) begin errors++; $display("FAIL t3_valid got=%0b exp=1", bin_valid); end
        checks++; if (frame_drop !== exp_drop) begin errors++; $display("FAIL t3_drop got=%0b exp=%0b", frame_drop, exp_drop); end
        gap();
        checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL t4_clear got=%0b exp=0", id_clear); end
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL t4_drop got=%0b exp=0", frame_drop); end
    endtask

    task automatic readout(input bins_t exp);
        bin_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            checks++; if (bin_valid !== 1'b1) begin errors++; $display("FAIL rd_valid i=%0d got=%0b exp=1", i, bin_valid); end
            checks++; if (bin_idx !== 3'(i)) begin errors++; $display("FAIL rd_idx got=%0d exp=%0d", bin_idx, i); end
            checks++; if (bin_data !== exp[i]) begin errors++; $display("FAIL rd_data i=%0d got=%0d exp=%0d", i, bin_data, exp[i]); end
            checks++; if (bin_last !== (i == NB-1)) begin errors++; $display("FAIL rd_last i=%0d got=%0b", i, bin_last); end
            @(negedge clk);
            #1;
        end
        bin_ready = 1'b0;
        checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL rd_done got=%0b exp=0", bin_valid); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({accum_valid, id_clear, bin_valid, bin_last, bin_idx, bin_data, frame_drop} !== '0) begin
            errors++;
            $display("FAIL %s_zero av=%0b clr=%0b v=%0b last=%0b idx=%0d data=%0d drop=%0b exp=all0",
                     tag, accum_valid, id_clear, bin_valid, bin_last, bin_idx, bin_data, frame_drop);
        end
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL %s_dropcnt got=%0d exp=0", tag, drop_cnt); end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; hist_enable = 1'b0; bin_ready = 1'b0; pix = 8'h00;
        video_valid = 1'b1; video_sof = 1'b1; video_eof = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        video_valid = 1'b0; video_sof = 1'b0;
    endtask

    task automatic test_frame();
        bins_t e;
        hist_enable = 1'b1;
        gap();
        checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL en_clear got=%0b exp=1", id_clear); end
        gap();
        checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL en_clear_end got=%0b exp=0", id_clear); end
        av_cnt = 0;
        beat(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) beat(1'b0, 1'b0, 8'h00);
        beat(1'b0, 1'b1, 8'h00);
        checks++; if (av_cnt != 10) begin errors++; $display("FAIL frame_beats got=%0d exp=10", av_cnt); end
        post_eof(1'b0, 1'b0);
        e = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        readout(e);
    endtask

    task automatic test_same_beat();
        bins_t e;
        av_cnt = 0;
        beat(1'b1, 1'b1, 8'h45);
        gap();
        checks++; if (av_cnt != 1) begin errors++; $display("FAIL same_beats got=%0d exp=1", av_cnt); end
        // The settle gap above already consumed T+1; finish the sequence manually.
        gap();
        checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL same_t2_valid got=%0b exp=0", bin_valid); end
        gap();
        checks++; if (bin_valid !== 1'b1) begin errors++; $display("FAIL same_t3_valid got=%0b exp=1", bin_valid); end
        checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL same_t3_clear got=%0b exp=1", id_clear); end
        gap();
        e = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        readout(e);
    endtask

    task automatic test_drop();
        bins_t e;
        bin_ready = 1'b0;
        beat(1'b1, 1'b0, 8'h20);
        beat(1'b0, 1'b0, 8'h20);
        beat(1'b0, 1'b1, 8'hE0);
        post_eof(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 8'h60);
        post_eof(1'b1, 1'b1);
        checks++; if (bin_idx !== 3'd0) begin errors++; $display("FAIL drop_hold_idx got=%0d exp=0", bin_idx); end
`ifdef HIST_FRAME_CTRL_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        e = '{8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        readout(e);
    endtask

    task automatic test_skip_sof();
        bins_t e;
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b0, 1'b1, 8'h00);
        gap();
        av_cnt = 0;
        beat(1'b1, 1'b0, 8'h80);
        beat(1'b0, 1'b0, 8'h80);
        beat(1'b0, 1'b0, 8'h80);
        beat(1'b0, 1'b1, 8'h80);
        checks++; if (av_cnt != 0) begin errors++; $display("FAIL skip_beats got=%0d exp=0", av_cnt); end
        gap();
        e = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        readout(e);
        av_cnt = 0;
        beat(1'b1, 1'b0, 8'hA0);
        beat(1'b0, 1'b0, 8'hA0);
        beat(1'b0, 1'b1, 8'hA0);
        checks++; if (av_cnt != 3) begin errors++; $display("FAIL next_beats got=%0d exp=3", av_cnt); end
        post_eof(1'b0, 1'b0);
        e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0};
        readout(e);
    endtask

    task automatic test_enable_drop();
        av_cnt = 0;
        beat(1'b1, 1'b0, 8'h20);
        beat(1'b0, 1'b0, 8'h20);
        hist_enable = 1'b0;
        beat(1'b0, 1'b0, 8'h20);
        checks++; if (accum_valid !== 1'b0) begin errors++; $display("FAIL dis_av got=%0b exp=0", accum_valid); end
        beat(1'b0, 1'b1, 8'h20);
        checks++; if (av_cnt != 2) begin errors++; $display("FAIL dis_beats got=%0d exp=2", av_cnt); end
        for (int i = 0; i < 5; i++) begin
            gap();
            checks++;
            if ({frame_drop, id_clear, bin_valid} !== 3'b000) begin
                errors++;
                $display("FAIL dis_quiet i=%0d drop=%0b clr=%0b v=%0b exp=000", i, frame_drop, id_clear, bin_valid);
            end
        end
        hist_enable = 1'b1;
        gap();
        checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL reen_clear got=%0b exp=1", id_clear); end
        gap();
        checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL reen_clear_end got=%0b exp=0", id_clear); end
    endtask

    task automatic test_reset_readout();
        bins_t e;
        bin_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 8'(i * 32));
        post_eof(1'b0, 1'b0);
        bin_ready = 1'b1;
        repeat (3) @(negedge clk);
        bin_ready = 1'b0;
        #1;
        checks++; if (bin_idx !== 3'd3) begin errors++; $display("FAIL mid_idx got=%0d exp=3", bin_idx); end
        checks++; if (bin_data !== 8'd1) begin errors++; $display("FAIL mid_data got=%0d exp=1", bin_data); end
        video_valid = 1'b1; video_sof = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        video_valid = 1'b0; video_sof = 1'b0;
        for (int i = 0; i < 6; i++) begin
            gap();
            checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid i=%0d got=%0b exp=0", i, bin_valid); end
        end
        beat(1'b1, 1'b1, 8'hFF);
        post_eof(1'b0, 1'b0);
        e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        readout(e);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_same_beat();
        test_drop();
        test_skip_sof();
        test_enable_drop();
        test_reset_readout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hist_frame_ctrl.md
# hist_frame_ctrl

Frame-level controller for the 8-bin luma histogram accumulator. It gates pixel beats into the accumulator for exactly one frame (SOF to EOF), snapshots the accumulator's bin outputs at frame end, and issues the clear for the next frame. It serialises the snapshot to a downstream consumer over a valid/ready stream. It sits between the video input stream and the accumulator, and owns `id_clear` and the accumulator's valid input.

## Interface
- `NUM_BINS`, default 8: number of histogram bins; the index width is clog2(NUM_BINS).
- `BIN_W`, default 8: width of each bin value from the accumulator.
- `clk` input, 1: the only clock.
- `rst` input, 1: asynchronous, active-high reset.
- `hist_enable` input, 1: run enable, level-sensitive.
- `video_valid` input, 1: pixel beat valid.
- `video_sof` input, 1: first beat of a frame; qualified by `video_valid`.
- `video_eof` input, 1: last beat of a frame; qualified by `video_valid`.
- `accum_valid` output, 1: gated beat valid to the accumulator.
- `id_clear` output, 1: accumulator clear.
- `id_value` input, NUM_BINS*BIN_W: accumulator bins, bin 0 in the LSBs.
- `bin_data` output, BIN_W: streamed bin value.
- `bin_idx` output, clog2(NUM_BINS): index of the streamed bin.
- `bin_valid` output, 1: stream valid.
- `bin_ready` input, 1: stream ready.
- `bin_last` output, 1: high with bin NUM_BINS-1.
- `frame_drop` output, 1: one-cycle pulse when a completed frame is discarded.
- `drop_cnt` output, 16: saturating drop counter; present only under the macro.

## Operation
- FSM states and transitions:
  - IDLE goes to CLEAR when `hist_enable` is high.
  - CLEAR lasts 1 cycle with `id_clear` = 1, then goes to ARMED.
  - ARMED waits for `video_valid & video_sof`, then goes to ACCUM. If that same beat also has `video_eof`, it goes straight to SETTLE.
  - ACCUM goes to SETTLE on `video_valid & video_eof`.
  - SETTLE lasts 1 cycle (lets the final increment land), then goes to LATCH.
  - LATCH lasts 1 cycle, then goes to CLEAR.
- `accum_valid` is combinational and equals `video_valid & (state==ACCUM | (state==ARMED & video_sof))`. It is 0 in every other state, so the SOF and EOF beats themselves are counted.
- LATCH behaviour:
  - If the snapshot is empty, capture `id_value` into the snapshot register and set full.
  - If the snapshot is full, keep the old snapshot untouched and pulse `frame_drop`.
- Readout:
  - While the snapshot is full, `bin_valid` = 1, `bin_data` = snapshot bin `bin_idx`, and `bin_idx` starts at 0.
  - `bin_idx` advances on `bin_valid & bin_ready`.
  - Acceptance of bin NUM_BINS-1 clears full and resets `bin_idx` to 0.
  - Readout runs concurrently with accumulation of the next frame.
- A SOF arriving in SETTLE, LATCH or CLEAR: that frame is skipped entirely. It is not counted and not a drop; the block waits for the next SOF in ARMED.
- Extra SOF in ACCUM: ignored, accumulation continues. EOF in ARMED without SOF: ignored.
- `hist_enable` low in any state goes to IDLE on the next edge, with no latch and no clear. Any existing snapshot still drains.
- Reset:
  - The FSM goes to IDLE and the snapshot empties.
  - All outputs go to 0: `accum_valid`, `id_clear`, `bin_valid`, `bin_last`, `bin_idx`, `bin_data`, `frame_drop`, `drop_cnt`.
  - Reset in mid-readout discards the snapshot.

## Timing
- EOF beat accepted at cycle T, in ACCUM:
  - T+1: SETTLE.
  - T+2: LATCH; capture at the T+2 edge.
  - T+3: `bin_valid` = 1 and CLEAR (`id_clear` = 1).
  - T+4: accumulator is zero and state is ARMED.
- `frame_drop` is high during cycle T+3.
- Dead window after EOF is 3 cycles (SETTLE, LATCH, CLEAR), during which a SOF is skipped.
- Readout throughput is one bin per cycle with `bin_ready` held high. The minimum drain time is NUM_BINS cycles.
- `bin_data`, `bin_idx` and `bin_last` are stable while `bin_valid & !bin_ready`.

## Configuration
- `HIST_FRAME_CTRL_DROP_CNT_EN`:
  - Defined: `drop_cnt` port exists. It increments on each `frame_drop` pulse, saturates at 16'hFFFF, and clears only on `rst`.
  - Undefined: the port and the counter are absent. `frame_drop` behaviour is unchanged.

## Structure
- `hist_pkg` holds:
  - the FSM state enum (IDLE, CLEAR, ARMED, ACCUM, SETTLE, LATCH);
  - the default constants NUM_BINS = 8 and BIN_W = 8;
  - a `BIN_IDX_W` constant.
- One sub-module, `hist_snap_reader`, holds the snapshot register, full flag, index counter and stream outputs. It takes a `latch` strobe and returns `full`. The FSM and gating stay in the top level.

## Test plan
- Enable, then a 10-beat frame of value 0x00 with SOF/EOF: `accum_valid` high for exactly 10 beats, `id_clear` high 1 cycle at T+3, stream shows bin 0 = modelled value, bins 1-7 = 0, `bin_last` with idx 7.
- SOF and EOF on the same beat in ARMED: 1 beat gated, goes directly to SETTLE, snapshot taken at T+2.
- Hold `bin_ready` = 0 across two complete frames: second LATCH pulses `frame_drop` once, snapshot still holds frame 1 values, and `drop_cnt` = 1 with the macro defined.
- SOF issued 2 cycles after EOF: no `accum_valid` for that frame; the next SOF frame is accumulated normally.
- `hist_enable` dropped mid-ACCUM: next cycle in IDLE, `accum_valid` = 0, no `frame_drop`, no new snapshot; re-enable produces a CLEAR pulse.
- `rst` asserted during readout at `bin_idx` = 3: all outputs 0 immediately, `bin_valid` stays 0 after release until a new frame completes.
